nt_emotion_decoder: RTL and testbench

Consumer end of the neurotransmitter level bus. Reads the packed 10-bit neurotransmitter_level bus (five 2-bit channel levels from the nt_*_system blocks) and turns it into the one-hot emotional_state that the regulators consume. Each channel is debounced with a per-channel stability filter. A classifier maps the filtered levels to an emotion, and a dwell FSM enforces a minimum time in each emotional state.

---
 rtl/nt_emotion_decoder.sv | 149 ++++++++++++++
 tb/tb_nt_emotion_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nt_emotion_decoder.sv
// Neurotransmitter-level bus consumer: debounces five 2-bit channel levels, classifies
// them into a one-hot emotion and holds each new emotion for a minimum dwell time.
module nt_emotion_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [9:0] neurotransmitter_level,
    output logic [7:0] emotional_state,
    output logic       state_valid,
    output logic       state_changed
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);
    localparam logic [7:0] HOLD_C   = 8'(HOLD_CYCLES);

    localparam logic [7:0] EMO_PANIC    = 8'b1000_0000;
    localparam logic [7:0] EMO_STRESSED = 8'b0100_0000;
    localparam logic [7:0] EMO_ANXIOUS  = 8'b0010_0000;
    localparam logic [7:0] EMO_EXCITED  = 8'b0001_0000;
    localparam logic [7:0] EMO_HAPPY    = 8'b0000_1000;
    localparam logic [7:0] EMO_CALM     = 8'b0000_0100;
    localparam logic [7:0] EMO_SAD      = 8'b0000_0010;
    localparam logic [7:0] EMO_NEUTRAL  = 8'b0000_0001;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    logic [9:0] filt_all;
    logic [4:0] sat_next;

    // One stability filter per 2-bit channel; the change sample counts as the first.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_chan
            logic [1:0] lvl_in;
            logic [1:0] cand_q, cand_d;
            logic [3:0] cnt_q, cnt_d;
            logic [1:0] filt_q, filt_d;

            assign lvl_in = neurotransmitter_level[2*gi +: 2];

            always_comb begin
                cand_d = cand_q;
                cnt_d  = cnt_q;
                filt_d = filt_q;
                if (sample_en) begin
                    if (lvl_in != cand_q) begin
                        cand_d = lvl_in;
                        cnt_d  = 4'd1;
                    end else if (cnt_q < STABLE_C) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == STABLE_C - 4'd1) begin
                            filt_d = lvl_in;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cand_q <= 2'd0;
                    cnt_q  <= 4'd0;
                    filt_q <= 2'd0;
                end else begin
                    cand_q <= cand_d;
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_all[2*gi +: 2] = filt_q;
            assign sat_next[gi]        = (cnt_d == STABLE_C);
        end
    endgenerate

    logic [1:0] lvl_d, lvl_s, lvl_n, lvl_c, lvl_g;
    logic [7:0] target;

    assign lvl_d = filt_all[1:0];
    assign lvl_s = filt_all[3:2];
    assign lvl_n = filt_all[5:4];
    assign lvl_c = filt_all[7:6];
    assign lvl_g = filt_all[9:8];

    always_comb begin
        target = EMO_NEUTRAL;
        if (lvl_n == 2'd3 && lvl_c == 2'd3)       target = EMO_PANIC;
        else if (lvl_c >= 2'd2)                   target = EMO_STRESSED;
        else if (lvl_n >= 2'd2 && lvl_g <= 2'd1)  target = EMO_ANXIOUS;
        else if (lvl_d == 2'd3 && lvl_n >= 2'd2)  target = EMO_EXCITED;
        else if (lvl_d >= 2'd2 && lvl_s >= 2'd2)  target = EMO_HAPPY;
        else if (lvl_g >= 2'd2 && lvl_n == 2'd0)  target = EMO_CALM;
        else if (lvl_s == 2'd0 && lvl_d <= 2'd1)  target = EMO_SAD;
    end

    state_t     state_q;
    logic [7:0] emo_q;
    logic       valid_q;
    logic       changed_q;
    logic [7:0] dwell_q;

    // INIT exits once every channel will be saturated after this edge; no pulse on that exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            emo_q     <= EMO_NEUTRAL;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            dwell_q   <= 8'd0;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (&sat_next) begin
                        state_q <= ST_STABLE;
                        valid_q <= 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (target != emo_q) begin
                        emo_q     <= target;
                        changed_q <= 1'b1;
                        dwell_q   <= HOLD_C;
                        state_q   <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (sample_en) begin
                        dwell_q <= dwell_q - 8'd1;
                        if (dwell_q == 8'd1) begin
                            state_q <= ST_STABLE;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign emotional_state = emo_q;
    assign state_valid     = valid_q;
    assign state_changed   = changed_q;

endmodule

// File: tb/tb_nt_emotion_decoder.sv
// Directed bench for nt_emotion_decoder: init warm-up, debounce, priority, dwell,
// sample_en gating and reset mid-dwell, with hand-computed expectations.
module tb_nt_emotion_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b1;
    logic [9:0] bus = 10'h000;
    logic [7:0] emotional_state;
    logic       state_valid;
    logic       state_changed;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] E_PANIC    = 8'h80;
    localparam logic [7:0] E_STRESSED = 8'h40;
    localparam logic [7:0] E_ANXIOUS  = 8'h20;
    localparam logic [7:0] E_EXCITED  = 8'h10;
    localparam logic [7:0] E_HAPPY    = 8'h08;
    localparam logic [7:0] E_CALM     = 8'h04;
    localparam logic [7:0] E_SAD      = 8'h02;
    localparam logic [7:0] E_NEUTRAL  = 8'h01;

    nt_emotion_decoder #(.STABLE_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sample_en              (sample_en),
        .neurotransmitter_level (bus),
        .emotional_state        (emotional_state),
        .state_valid            (state_valid),
        .state_changed          (state_changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_en = 1'b1; bus = 10'h000;
        tick(); tick();
        total++;
        if (emotional_state !== E_NEUTRAL) begin
            bad++; $display("FAIL reset_emo: got %h want %h", emotional_state, E_NEUTRAL);
        end
        total++;
        if (state_valid !== 1'b0 || state_changed !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got valid=%b chg=%b want 0 0", state_valid, state_changed);
        end
        $display("reset: emo=%h valid=%b chg=%b", emotional_state, state_valid, state_changed);
    endtask

    task automatic test_init();
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (state_valid !== 1'b0 || emotional_state !== E_NEUTRAL) begin
                bad++; $display("FAIL init_wait%0d: got valid=%b emo=%h want 0 %h", i, state_valid, emotional_state, E_NEUTRAL);
            end
        end
        tick();
        total++;
        if (state_valid !== 1'b1 || emotional_state !== E_NEUTRAL || state_changed !== 1'b0) begin
            bad++; $display("FAIL init_valid: got valid=%b emo=%h chg=%b want 1 %h 0", state_valid, emotional_state, state_changed, E_NEUTRAL);
        end
        tick();
        total++;
        if (emotional_state !== E_SAD || state_changed !== 1'b1) begin
            bad++; $display("FAIL init_sad: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_SAD);
        end
        $display("init: emo=%h valid=%b chg=%b", emotional_state, state_valid, state_changed);
    endtask

    task automatic test_debounce();
        bus = 10'h00A;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (emotional_state !== E_HAPPY || state_changed !== 1'b0) begin
            bad++; $display("FAIL deb_happy: got emo=%h chg=%b want %h 0", emotional_state, state_changed, E_HAPPY);
        end
        for (int i = 0; i < 13; i++) begin
            bus = (i < 3) ? 10'h0CA : 10'h00A;
            tick();
            total++;
            if (emotional_state !== E_HAPPY || state_changed !== 1'b0) begin
                bad++; $display("FAIL deb_glitch%0d: got emo=%h chg=%b want %h 0", i, emotional_state, state_changed, E_HAPPY);
            end
        end
        bus = 10'h0CA;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (emotional_state !== E_HAPPY || state_changed !== 1'b0) begin
                bad++; $display("FAIL deb_hold%0d: got emo=%h chg=%b want %h 0", i, emotional_state, state_changed, E_HAPPY);
            end
        end
        tick();
        total++;
        if (emotional_state !== E_STRESSED || state_changed !== 1'b1) begin
            bad++; $display("FAIL deb_stressed: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_STRESSED);
        end
        $display("debounce: emo=%h chg=%b", emotional_state, state_changed);
    endtask

    task automatic test_priority();
        bus = 10'h0FB;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (emotional_state !== E_STRESSED) begin
            bad++; $display("FAIL prio_dwell: got emo=%h want %h", emotional_state, E_STRESSED);
        end
        tick();
        total++;
        if (emotional_state !== E_PANIC || state_changed !== 1'b1) begin
            bad++; $display("FAIL prio_panic: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_PANIC);
        end
        bus = 10'h27B;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (emotional_state !== E_PANIC || state_changed !== 1'b0) begin
            bad++; $display("FAIL prio_hold: got emo=%h chg=%b want %h 0", emotional_state, state_changed, E_PANIC);
        end
        tick();
        total++;
        if (emotional_state !== E_EXCITED || state_changed !== 1'b1) begin
            bad++; $display("FAIL prio_excited: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_EXCITED);
        end
        $display("priority: emo=%h chg=%b", emotional_state, state_changed);
    endtask

    task automatic test_dwell();
        for (int i = 0; i < 10; i++) tick();
        bus = 10'h024;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (emotional_state !== E_EXCITED) begin
            bad++; $display("FAIL dwell_pre: got emo=%h want %h", emotional_state, E_EXCITED);
        end
        tick();
        total++;
        if (emotional_state !== E_ANXIOUS || state_changed !== 1'b1) begin
            bad++; $display("FAIL dwell_anx: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_ANXIOUS);
        end
        bus = 10'h200;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (emotional_state !== E_ANXIOUS || state_changed !== 1'b0) begin
                bad++; $display("FAIL dwell_hold%0d: got emo=%h chg=%b want %h 0", i, emotional_state, state_changed, E_ANXIOUS);
            end
        end
        tick();
        total++;
        if (emotional_state !== E_CALM || state_changed !== 1'b1) begin
            bad++; $display("FAIL dwell_calm: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_CALM);
        end
        tick();
        total++;
        if (state_changed !== 1'b0) begin
            bad++; $display("FAIL dwell_pulse: got chg=%b want 0", state_changed);
        end
        $display("dwell: emo=%h chg=%b", emotional_state, state_changed);
    endtask

    task automatic test_gating();
        sample_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus = (i % 2 == 0) ? 10'h0C0 : 10'h3FF;
            tick();
            total++;
            if (emotional_state !== E_CALM || state_changed !== 1'b0) begin
                bad++; $display("FAIL gate_hold%0d: got emo=%h chg=%b want %h 0", i, emotional_state, state_changed, E_CALM);
            end
        end
        sample_en = 1'b1;
        bus = 10'h0C0;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (emotional_state !== E_CALM) begin
            bad++; $display("FAIL gate_resume: got emo=%h want %h", emotional_state, E_CALM);
        end
        tick();
        total++;
        if (emotional_state !== E_STRESSED || state_changed !== 1'b1) begin
            bad++; $display("FAIL gate_stressed: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_STRESSED);
        end
        $display("gating: emo=%h chg=%b", emotional_state, state_changed);
    endtask

    task automatic test_reset_mid_dwell();
        tick(); tick();
        rst = 1'b1;
        tick();
        total++;
        if (emotional_state !== E_NEUTRAL || state_valid !== 1'b0 || state_changed !== 1'b0) begin
            bad++; $display("FAIL rst_dwell: got emo=%h valid=%b chg=%b want %h 0 0", emotional_state, state_valid, state_changed, E_NEUTRAL);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (state_valid !== 1'b0 || emotional_state !== E_NEUTRAL) begin
                bad++; $display("FAIL rst_warm%0d: got valid=%b emo=%h want 0 %h", i, state_valid, emotional_state, E_NEUTRAL);
            end
        end
        tick();
        total++;
        if (state_valid !== 1'b1 || emotional_state !== E_NEUTRAL) begin
            bad++; $display("FAIL rst_valid: got valid=%b emo=%h want 1 %h", state_valid, emotional_state, E_NEUTRAL);
        end
        tick();
        total++;
        if (emotional_state !== E_STRESSED || state_changed !== 1'b1) begin
            bad++; $display("FAIL rst_stressed: got emo=%h chg=%b want %h 1", emotional_state, state_changed, E_STRESSED);
        end
        $display("reset_mid_dwell: emo=%h valid=%b chg=%b", emotional_state, state_valid, state_changed);
    endtask

    initial begin
        test_reset();
        test_init();
        test_debounce();
        test_priority();
        test_dwell();
        test_gating();
        test_reset_mid_dwell();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
